sha256_mem_arbiter: RTL

SHA256_MEM_ARBITER -- requirements
Module: sha256_mem_arbiter

---
 rtl/sha256_mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sha256_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_mem_arbiter
//   Shares one single-port memory between NUM_REQ hash cores. An owner keeps
//   the port for a burst while it holds req. It is pre-empted after MAX_BURST
//   accesses only if another core is waiting. Owners are chosen round-robin,
//   starting after the last owner. Read data is broadcast to every core, and
//   a registered per-core rvalid marks which core the data belongs to.
//
// Ports
//   clk            : single clock, rising edge
//   reset_n        : synchronous active-low reset
//   req[i]         : core i requests the port (held for the whole burst)
//   we[i]          : core i access is a write (1) or a read (0)
//   addr           : per-core 16-bit word address, slice i = [16i+15:16i]
//   wdata          : per-core 32-bit write data, slice i = [32i+31:32i]
//   gnt            : registered one-hot grant (or all zero)
//   rdata          : memory read data, broadcast
//   rvalid[i]      : rdata is valid for core i this cycle
//   mem_clk        : memory clock (same as clk)
//   mem_we         : memory write enable
//   mem_addr       : memory word address
//   mem_write_data : memory write data
//   mem_read_data  : memory read data, one cycle after the read address
// ---------------------------------------------------------------------------
module sha256_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*16-1:0] addr,
  input  logic [NUM_REQ*32-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [31:0]           rdata,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] rvalid_d;
  logic              access;

  // First set bit of cand, scanning after+1, after+2, ... modulo NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                            input logic [IW-1:0]      after);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(after) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign mem_clk = clk;
  assign rdata   = mem_read_data;
  assign access  = (state_q == OWN) && req[own_q];

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      burst_q <= '0;
      gnt     <= '0;
      rvalid  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      gnt     <= gnt_d;
      rvalid  <= rvalid_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic [NUM_REQ-1:0] others;
    logic               release_now;
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    own_d       = own_q;
    last_d      = last_q;
    burst_d     = burst_q;
    gnt_d       = gnt;
    rvalid_d    = gnt & req & ~we;
    others      = req;
    others[own_q] = 1'b0;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          own_d   = rr_pick(req, last_q);
          gnt_d   = one_hot(rr_pick(req, last_q));
          burst_d = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (access) begin
          burst_d = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
          // This access completes the burst allowance (or the count has
          // already saturated), so give way if anyone else is waiting.
          if ((burst_q >= BW'(MAX_BURST - 1)) && (|others))
            release_now = 1'b1;
        end else begin
          release_now = 1'b1;
        end

        if (release_now) begin
          last_d  = own_q;
          burst_d = '0;
          if (|others) begin
            // Hand over directly: the owner's own bit is masked, so the scan
            // from own_q+1 never lands back on it.
            own_d = rr_pick(others, own_q);
            gnt_d = one_hot(rr_pick(others, own_q));
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output logic: memory port follows the owner only on access cycles.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (access) begin
      mem_we         = we[own_q];
      mem_addr       = addr[16*int'(own_q) +: 16];
      mem_write_data = wdata[32*int'(own_q) +: 32];
    end
  end

endmodule
